hazard_ctrl_unit: RTL and testbench

// - Consumer-side control for the ID/EX register. It reads the ID/EX outputs (rs1/rs2/rd, MemRead, RegWrite)

---
 rtl/hazard_ctrl_unit_pkg.sv | 25 ++
 rtl/hazard_ctrl_unit_forward_sel.sv | 23 ++
 rtl/hazard_ctrl_unit.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// rtl/hazard_ctrl_unit_pkg.sv - shared pipeline encodings for the hazard control unit
package hazard_ctrl_unit_pkg;

  // ALU operand source selects
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  // Architectural zero register, never a real producer
  localparam logic [4:0] REG_X0 = 5'd0;

  // Flush sequencer states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hcu_state_e;

  // True when a stage really produces the register a consumer wants
  function automatic logic producer_hit(input logic       reg_write,
                                        input logic [4:0] dst_rd,
                                        input logic [4:0] src_rs);
    return reg_write && (dst_rd != REG_X0) && (dst_rd == src_rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_forward_sel.sv
// rtl/hazard_ctrl_unit_forward_sel.sv - ALU operand forwarding select for one source operand
import hazard_ctrl_unit_pkg::*;

module forward_sel (
  input  logic [4:0] src_rs,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_reg_write,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_reg_write,
  output logic [1:0] fwd_sel
);

  // EX/MEM holds the younger result, so it is checked first
  always_comb begin
    fwd_sel = FWD_REGFILE;
    if (producer_hit(exmem_reg_write, exmem_rd, src_rs)) begin
      fwd_sel = FWD_EXMEM;
    end else if (producer_hit(memwb_reg_write, memwb_rd, src_rs)) begin
      fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline stall, flush, freeze and forwarding control
import hazard_ctrl_unit_pkg::*;

module hazard_ctrl_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         ifid_rs1,
  input  logic [4:0]         ifid_rs2,
  input  logic               ifid_use_rs1,
  input  logic               ifid_use_rs2,
  input  logic [4:0]         idex_rs1,
  input  logic [4:0]         idex_rs2,
  input  logic [4:0]         idex_rd,
  input  logic               idex_MemRead,
  input  logic [4:0]         exmem_rd,
  input  logic               exmem_RegWrite,
  input  logic [4:0]         memwb_rd,
  input  logic               memwb_RegWrite,
  input  logic               branch_taken_ex,
  input  logic               mem_busy,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               pipe_freeze,
  output logic [1:0]         forward_a,
  output logic [1:0]         forward_b,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  // Cycles still to flush after the branch cycle itself
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  hcu_state_e         state_q, state_d;
  logic [1:0]         fcnt_q, fcnt_d;
  logic [COUNT_W-1:0] stall_q, stall_d;
  logic [COUNT_W-1:0] flush_q, flush_d;

  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  forward_sel u_fwd_a (
    .src_rs          (idex_rs1),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_RegWrite),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_RegWrite),
    .fwd_sel         (fwd_a_raw)
  );

  forward_sel u_fwd_b (
    .src_rs          (idex_rs2),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_RegWrite),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_RegWrite),
    .fwd_sel         (fwd_b_raw)
  );

  // Load in EX whose destination the ID instruction is about to read
  always_comb begin
    load_use = idex_MemRead && (idex_rd != REG_X0) &&
               ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
  end

  // Forwarding selects are parked on the register file while in reset
  always_comb begin
    forward_a = reset ? fwd_a_raw : FWD_REGFILE;
    forward_b = reset ? fwd_b_raw : FWD_REGFILE;
  end

  // Next state and pipeline controls; freeze beats flush beats load-use
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;

    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
      fcnt_d      = 2'd0;
    end else if (mem_busy) begin
      // Whole pipe holds; the sequencer waits with it
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      stall_inc   = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      // EX holds a bubble here, so a branch flag is meaningless and ignored
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (fcnt_q <= 2'd1) begin
        state_d = ST_RUN;
        fcnt_d  = 2'd0;
      end else begin
        fcnt_d = fcnt_q - 2'd1;
      end
    end else if (branch_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = FLUSH_RELOAD;
      end
    end else if (load_use) begin
      // One bubble clears MemRead in EX, so this lasts a single cycle
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != '1)) begin
      stall_d = stall_q + COUNT_ONE;
    end
    if (flush_inc && (flush_q != '1)) begin
      flush_d = flush_q + COUNT_ONE;
    end
  end

  // State, flush counter and perf counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic          ifid_use_rs1, ifid_use_rs2, idex_MemRead, exmem_RegWrite, memwb_RegWrite;
  logic          branch_taken_ex, mem_busy;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
  logic [1:0]    forward_a, forward_b;
  logic [CW-1:0] stall_count, flush_count;

  hazard_ctrl_unit #(.FLUSH_CYCLES(FC), .COUNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_use_rs1    (ifid_use_rs1),
    .ifid_use_rs2    (ifid_use_rs2),
    .idex_rs1        (idex_rs1),
    .idex_rs2        (idex_rs2),
    .idex_rd         (idex_rd),
    .idex_MemRead    (idex_MemRead),
    .exmem_rd        (exmem_rd),
    .exmem_RegWrite  (exmem_RegWrite),
    .memwb_rd        (memwb_rd),
    .memwb_RegWrite  (memwb_RegWrite),
    .branch_taken_ex (branch_taken_ex),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .pipe_freeze     (pipe_freeze),
    .forward_a       (forward_a),
    .forward_b       (forward_b),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  typedef struct {
    int pcw, ifw, ifl, bub, frz, fa, fb, sc, fcn, id;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending flush cycles and plain integer event counts
  int m_flush_left = 0;
  int m_stall = 0;
  int m_flush = 0;
  int step_id = 0;

  function automatic int fwd_model(input int rs);
    if (exmem_RegWrite && exmem_rd != 0 && int'(exmem_rd) == rs) return 2;
    if (memwb_RegWrite && memwb_rd != 0 && int'(memwb_rd) == rs) return 1;
    return 0;
  endfunction

  task automatic step();
    exp_t e;
    bit hazard;
    hazard = idex_MemRead && idex_rd != 0 &&
             ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
    e.id = step_id;
    step_id++;
    if (!reset) begin
      m_flush_left = 0; m_stall = 0; m_flush = 0;
      e.pcw = 0; e.ifw = 0; e.ifl = 1; e.bub = 1; e.frz = 0; e.fa = 0; e.fb = 0;
      e.sc = 0; e.fcn = 0;
    end else begin
      e.sc = m_stall; e.fcn = m_flush;
      e.fa = fwd_model(int'(idex_rs1));
      e.fb = fwd_model(int'(idex_rs2));
      e.pcw = 1; e.ifw = 1; e.ifl = 0; e.bub = 0; e.frz = 0;
      if (mem_busy) begin
        e.pcw = 0; e.ifw = 0; e.frz = 1;
        if (m_stall < CMAX) m_stall++;
      end else if (m_flush_left > 0) begin
        e.ifl = 1; e.bub = 1;
        m_flush_left--;
      end else if (branch_taken_ex) begin
        e.ifl = 1; e.bub = 1;
        if (m_flush < CMAX) m_flush++;
        m_flush_left = FC - 1;
      end else if (hazard) begin
        e.pcw = 0; e.ifw = 0; e.bub = 1;
        if (m_stall < CMAX) m_stall++;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b1;
    ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_MemRead = 0;
    exmem_rd = 0; exmem_RegWrite = 0; memwb_rd = 0; memwb_RegWrite = 0;
    branch_taken_ex = 0; mem_busy = 0;
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  task automatic randomize_inputs();
    reset = ($urandom_range(0, 199) != 0);
    ifid_rs1 = rreg(); ifid_rs2 = rreg(); idex_rs1 = rreg(); idex_rs2 = rreg();
    idex_rd = rreg(); exmem_rd = rreg(); memwb_rd = rreg();
    ifid_use_rs1 = 1'($urandom); ifid_use_rs2 = 1'($urandom);
    idex_MemRead = 1'($urandom); exmem_RegWrite = 1'($urandom); memwb_RegWrite = 1'($urandom);
    branch_taken_ex = ($urandom_range(0, 7) == 0);
    mem_busy = ($urandom_range(0, 5) == 0);
  endtask

  task automatic chk(input string name, input int id, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, id, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_write",    e.id, int'(pc_write),    e.pcw);
      chk("ifid_write",  e.id, int'(ifid_write),  e.ifw);
      chk("ifid_flush",  e.id, int'(ifid_flush),  e.ifl);
      chk("idex_bubble", e.id, int'(idex_bubble), e.bub);
      chk("pipe_freeze", e.id, int'(pipe_freeze), e.frz);
      chk("forward_a",   e.id, int'(forward_a),   e.fa);
      chk("forward_b",   e.id, int'(forward_b),   e.fb);
      chk("stall_count", e.id, int'(stall_count), e.sc);
      chk("flush_count", e.id, int'(flush_count), e.fcn);
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(); step();
    clear_inputs();
    step();

    // load-use on rs1, then the bubble drops MemRead
    idex_MemRead = 1; idex_rd = 5; ifid_rs1 = 5; ifid_use_rs1 = 1;
    step();
    idex_MemRead = 0;
    step();

    // x0 never stalls nor forwards
    idex_MemRead = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1;
    exmem_rd = 0; exmem_RegWrite = 1; idex_rs1 = 0;
    step();
    clear_inputs();

    // forward priority on operand B
    exmem_rd = 7; memwb_rd = 7; exmem_RegWrite = 1; memwb_RegWrite = 1; idex_rs2 = 7;
    step();
    exmem_RegWrite = 0;
    step();
    clear_inputs();

    // branch flush lasting FC cycles, branch asserted again inside FLUSH
    branch_taken_ex = 1;
    step(); step();
    branch_taken_ex = 0;
    step(); step(); step();

    // branch with a load-use hazard present: flush wins
    idex_MemRead = 1; idex_rd = 9; ifid_rs2 = 9; ifid_use_rs2 = 1; branch_taken_ex = 1;
    step();
    clear_inputs();
    step(); step(); step();

    // same collision under mem_busy: freeze, flush once busy drops
    idex_MemRead = 1; idex_rd = 9; ifid_rs2 = 9; ifid_use_rs2 = 1; branch_taken_ex = 1; mem_busy = 1;
    step(); step();
    mem_busy = 0;
    step();
    clear_inputs();
    mem_busy = 1;
    step();
    mem_busy = 0;
    step(); step(); step();

    // reset in the middle of a flush sequence
    branch_taken_ex = 1;
    step();
    branch_taken_ex = 0;
    reset = 0;
    step();
    reset = 1;
    step(); step();

    // stall counter saturation
    mem_busy = 1;
    repeat (20) step();
    mem_busy = 0;
    step();

    // randomized traffic
    repeat (2000) begin
      randomize_inputs();
      step();
    end
    clear_inputs();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
